// File: rtl/dice_race_pkg.sv
// Shared types for the dice race game: colour codes, qualifier FSM states
// and the colour-to-steps mapping.
package dice_race_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2,
        NONE  = 2'd3
    } color_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_WHITE = 3'd1,
        ARMED      = 3'd2,
        CONFIRM    = 3'd3,
        REPORT     = 3'd4
    } state_e;

    function automatic logic [2:0] color_steps(color_e c);
        case (c)
            RED:     return 3'd1;
            GREEN:   return 3'd2;
            BLUE:    return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/frame_streak_counter.sv
// Saturating consecutive-match counter: clear wins over load (restart at 1),
// load wins over increment; increments stop at STABLE_FRAMES.
module frame_streak_counter
    import dice_race_pkg::*;
#(
    parameter int STABLE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(STABLE_FRAMES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc && count != SAT) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dice_roll_qualifier.sv
// Qualifies a dice roll from colour-detector frames: wait for an empty tray,
// then require STABLE_FRAMES agreeing colour frames before reporting.
module dice_roll_qualifier
    import dice_race_pkg::*;
#(
    parameter int          STABLE_FRAMES  = 4,
    parameter logic [15:0] CONF_MIN       = 16'd2000,
    parameter int          TIMEOUT_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        result_ready,
    input  logic [1:0]  stable_color,
    input  logic        white_stable,
    input  logic [15:0] stable_confidence,
    input  logic        dice_ack,
    output logic        dice_valid,
    output logic [1:0]  dice_value,
    output logic [2:0]  dice_steps,
    output logic        timeout_pulse,
    output logic [2:0]  fsm_state
);

    localparam int               CYC_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST    = CYC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STREAK_LAST = CNT_W'(STABLE_FRAMES - 1);
    localparam bit               ONE_FRAME   = (STABLE_FRAMES == 1);

    state_e             state;
    color_e             latched;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   white_cnt;
    logic [CNT_W-1:0]   colour_cnt;
    color_e             frame_color;
    logic               white_frame;
    logic               colour_frame;
    logic               same_colour;
    logic               timeout_hit;
    logic               w_clear;
    logic               w_inc;
    logic               c_clear;
    logic               c_load;
    logic               c_inc;

    assign frame_color  = color_e'(stable_color);
    assign white_frame  = result_ready && white_stable;
    assign colour_frame = result_ready && !white_stable && (frame_color != NONE)
                          && (stable_confidence >= CONF_MIN);
    assign same_colour  = colour_frame && (frame_color == latched);
    // A frame arriving on the last cycle beats the timeout.
    assign timeout_hit  = (state == CONFIRM) && !result_ready && (cyc_cnt == CYC_LAST);

    assign w_clear = !enable || (state != WAIT_WHITE) || (result_ready && !white_stable);
    assign w_inc   = (state == WAIT_WHITE) && white_frame;

    assign c_clear = !enable || !((state == ARMED) || (state == CONFIRM))
                     || ((state == CONFIRM) && (white_frame || timeout_hit));
    assign c_load  = colour_frame && ((state == ARMED) || ((state == CONFIRM) && !same_colour));
    assign c_inc   = (state == CONFIRM) && same_colour;

    frame_streak_counter #(.STABLE_FRAMES(STABLE_FRAMES)) u_white_streak (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .load  (1'b0),
        .inc   (w_inc),
        .count (white_cnt)
    );

    frame_streak_counter #(.STABLE_FRAMES(STABLE_FRAMES)) u_colour_streak (
        .clk   (clk),
        .reset (reset),
        .clear (c_clear),
        .load  (c_load),
        .inc   (c_inc),
        .count (colour_cnt)
    );

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            latched       <= RED;
            cyc_cnt       <= '0;
            dice_valid    <= 1'b0;
            dice_value    <= '0;
            dice_steps    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            cyc_cnt       <= '0;
            if (!enable) begin
                state      <= IDLE;
                dice_valid <= 1'b0;
                dice_value <= '0;
                dice_steps <= '0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_WHITE;
                    WAIT_WHITE: begin
                        if (white_frame && white_cnt == STREAK_LAST) state <= ARMED;
                    end
                    ARMED: begin
                        if (colour_frame) begin
                            latched <= frame_color;
                            if (ONE_FRAME) begin
                                state      <= REPORT;
                                dice_valid <= 1'b1;
                                dice_value <= frame_color;
                                dice_steps <= color_steps(frame_color);
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (white_frame) begin
                            state <= ARMED;
                        end else if (colour_frame) begin
                            latched <= frame_color;
                            if ((same_colour && colour_cnt == STREAK_LAST) || (!same_colour && ONE_FRAME)) begin
                                state      <= REPORT;
                                dice_valid <= 1'b1;
                                dice_value <= frame_color;
                                dice_steps <= color_steps(frame_color);
                            end
                        end else if (timeout_hit) begin
                            timeout_pulse <= 1'b1;
                            state         <= ARMED;
                        end else if (!result_ready) begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    REPORT: begin
                        // Frames arriving here are dropped; only the ack matters.
                        if (dice_ack) begin
                            state      <= WAIT_WHITE;
                            dice_valid <= 1'b0;
                            dice_value <= '0;
                            dice_steps <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dice_roll_qualifier.sv
// Directed bench for dice_roll_qualifier: a per-frame vector table plus
// hand-written sequences for report hold, timeout, enable drop and reset.
module tb_dice_roll_qualifier;

    localparam logic [2:0] S_I = 3'd0, S_W = 3'd1, S_A = 3'd2, S_C = 3'd3, S_R = 3'd4;
    localparam logic [1:0] C_R = 2'd0, C_G = 2'd1, C_B = 2'd2, C_N = 2'd3;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        result_ready;
    logic [1:0]  stable_color;
    logic        white_stable;
    logic [15:0] stable_confidence;
    logic        dice_ack;
    logic        dice_valid;
    logic [1:0]  dice_value;
    logic [2:0]  dice_steps;
    logic        timeout_pulse;
    logic [2:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        en;
        logic        rr;
        logic        white;
        logic [1:0]  color;
        logic [15:0] conf;
        logic        ack;
        logic [2:0]  st;
        logic        valid;
        logic [1:0]  value;
        logic [2:0]  steps;
    } vec_t;

    vec_t vt[$];

    dice_roll_qualifier #(
        .STABLE_FRAMES  (4),
        .CONF_MIN       (16'd2000),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .result_ready      (result_ready),
        .stable_color      (stable_color),
        .white_stable      (white_stable),
        .stable_confidence (stable_confidence),
        .dice_ack          (dice_ack),
        .dice_valid        (dice_valid),
        .dice_value        (dice_value),
        .dice_steps        (dice_steps),
        .timeout_pulse     (timeout_pulse),
        .fsm_state         (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic rr, input logic white, input logic [1:0] color,
                       input logic [15:0] conf, input logic ack, input logic [2:0] st,
                       input logic valid, input logic [1:0] value, input logic [2:0] steps);
        vt.push_back('{en, rr, white, color, conf, ack, st, valid, value, steps});
    endtask

    task automatic add_white(input logic [2:0] st);
        add(1, 1, 1, C_N, 16'd0, 0, st, 0, 2'd0, 3'd0);
    endtask

    task automatic add_col(input logic [1:0] c, input logic [15:0] conf, input logic [2:0] st,
                           input logic valid, input logic [1:0] value, input logic [2:0] steps);
        add(1, 1, 0, c, conf, 0, st, valid, value, steps);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic w, input logic [1:0] c, input logic [15:0] conf, input logic ack);
        result_ready = 1'b1; white_stable = w; stable_color = c;
        stable_confidence = conf; dice_ack = ack;
        tick();
        result_ready = 1'b0; white_stable = 1'b0; dice_ack = 1'b0;
    endtask

    task automatic frame(input logic w, input logic [1:0] c, input logic [15:0] conf, input logic ack);
        pulse(w, c, conf, ack);
        tick();
    endtask

    task automatic whites4();
        for (int k = 0; k < 4; k++) frame(1'b1, C_N, 16'd0, 1'b0);
    endtask

    initial begin
        int pulses;
        int first;

        reset = 1'b0; enable = 1'b0; result_ready = 1'b0; white_stable = 1'b0;
        stable_color = 2'd0; stable_confidence = 16'd0; dice_ack = 1'b0;

        // Enable, 4 whites, 4 greens -> green/2 one cycle after the 4th pulse
        add(1, 0, 0, C_N, 16'd0, 0, S_W, 0, 2'd0, 3'd0);
        for (int k = 0; k < 3; k++) add_white(S_W);
        add_white(S_A);
        for (int k = 0; k < 3; k++) add_col(C_G, 16'd3000, S_C, 0, 2'd0, 3'd0);
        add_col(C_G, 16'd3000, S_R, 1, 2'd1, 3'd2);
        add(1, 0, 0, C_N, 16'd0, 1, S_W, 0, 2'd0, 3'd0);
        // red, red, blue x4 -> blue/3 on the 6th frame only
        for (int k = 0; k < 3; k++) add_white(S_W);
        add_white(S_A);
        add_col(C_R, 16'd3000, S_C, 0, 2'd0, 3'd0);
        add_col(C_R, 16'd3000, S_C, 0, 2'd0, 3'd0);
        for (int k = 0; k < 3; k++) add_col(C_B, 16'd3000, S_C, 0, 2'd0, 3'd0);
        add_col(C_B, 16'd3000, S_R, 1, 2'd2, 3'd3);
        add(1, 0, 0, C_N, 16'd0, 1, S_W, 0, 2'd0, 3'd0);
        // a non-white frame restarts the white streak
        for (int k = 0; k < 3; k++) add_white(S_W);
        add_col(C_N, 16'd0, S_W, 0, 2'd0, 3'd0);
        for (int k = 0; k < 3; k++) add_white(S_W);
        add_white(S_A);
        // confidence threshold, NONE colour is neutral
        add_col(C_G, 16'd1999, S_A, 0, 2'd0, 3'd0);
        add_col(C_G, 16'd1999, S_A, 0, 2'd0, 3'd0);
        add_col(C_G, 16'd2000, S_C, 0, 2'd0, 3'd0);
        add_col(C_N, 16'd5000, S_C, 0, 2'd0, 3'd0);
        add_col(C_G, 16'd2000, S_C, 0, 2'd0, 3'd0);
        add_col(C_G, 16'd2000, S_C, 0, 2'd0, 3'd0);
        add_col(C_G, 16'd2000, S_R, 1, 2'd1, 3'd2);
        // ack with a coincident white frame: frame discarded, 4 fresh whites needed
        add(1, 1, 1, C_N, 16'd0, 1, S_W, 0, 2'd0, 3'd0);
        for (int k = 0; k < 3; k++) add_white(S_W);
        add_white(S_A);
        // white during CONFIRM returns to ARMED and drops the streak
        add_col(C_R, 16'd3000, S_C, 0, 2'd0, 3'd0);
        add_white(S_A);
        for (int k = 0; k < 3; k++) add_col(C_R, 16'd3000, S_C, 0, 2'd0, 3'd0);
        add_col(C_R, 16'd3000, S_R, 1, 2'd0, 3'd1);
        add(1, 0, 0, C_N, 16'd0, 1, S_W, 0, 2'd0, 3'd0);
        // ack outside REPORT is ignored
        add(1, 0, 0, C_N, 16'd0, 1, S_W, 0, 2'd0, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, fsm_state}, {29'd0, S_I});
        check("reset_valid_steps", {dice_valid, dice_value, dice_steps, timeout_pulse}, 32'd0);
        reset = 1'b1;
        check("release_state", {29'd0, fsm_state}, {29'd0, S_I});
        tick();
        check("idle_no_enable", {29'd0, fsm_state}, {29'd0, S_I});

        for (int i = 0; i < vt.size(); i++) begin
            enable = vt[i].en; result_ready = vt[i].rr; white_stable = vt[i].white;
            stable_color = vt[i].color; stable_confidence = vt[i].conf; dice_ack = vt[i].ack;
            tick();
            check($sformatf("vec%0d_state", i), {29'd0, fsm_state}, {29'd0, vt[i].st});
            check($sformatf("vec%0d_valid", i), {31'd0, dice_valid}, {31'd0, vt[i].valid});
            check($sformatf("vec%0d_steps", i), {29'd0, dice_steps}, {29'd0, vt[i].steps});
            if (vt[i].valid)
                check($sformatf("vec%0d_value", i), {30'd0, dice_value}, {30'd0, vt[i].value});
            check($sformatf("vec%0d_timeout", i), {31'd0, timeout_pulse}, 32'd0);
            result_ready = 1'b0; dice_ack = 1'b0;
            tick();
        end

        // REPORT held across 100 ignored frames, then ack with a frame
        whites4();
        for (int k = 0; k < 4; k++) frame(1'b0, C_B, 16'd3000, 1'b0);
        check("hold_enter", {23'd0, fsm_state, dice_valid, dice_value, dice_steps},
              {23'd0, S_R, 1'b1, C_B, 3'd3});
        for (int i = 0; i < 100; i++) begin
            frame((i % 3) == 0, 2'(i % 4), (i % 2 == 0) ? 16'd3000 : 16'd100, 1'b0);
            check($sformatf("hold_%0d", i), {23'd0, fsm_state, dice_valid, dice_value, dice_steps},
                  {23'd0, S_R, 1'b1, C_B, 3'd3});
        end
        pulse(1'b1, C_N, 16'd0, 1'b1);
        check("ack_state", {29'd0, fsm_state}, {29'd0, S_W});
        check("ack_valid_steps", {28'd0, dice_valid, dice_steps}, 32'd0);
        tick();

        // Confirmation timeout after 50 frameless cycles
        whites4();
        pulse(1'b0, C_R, 16'd3000, 1'b0);
        check("to_confirm", {29'd0, fsm_state}, {29'd0, S_C});
        pulses = 0; first = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (timeout_pulse) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("to_pulse_count", pulses, 1);
        check("to_pulse_cycle", first, 50);
        check("to_state", {29'd0, fsm_state}, {29'd0, S_A});

        // Drop enable while reporting
        for (int k = 0; k < 4; k++) frame(1'b0, C_G, 16'd3000, 1'b0);
        check("en_report", {27'd0, dice_valid, dice_value, dice_steps}, {27'd0, 1'b1, C_G, 3'd2});
        enable = 1'b0;
        tick();
        check("en_drop_state", {29'd0, fsm_state}, {29'd0, S_I});
        check("en_drop_valid", {28'd0, dice_valid, dice_steps}, 32'd0);
        enable = 1'b1;
        tick();
        check("en_back", {29'd0, fsm_state}, {29'd0, S_W});

        // Asynchronous reset mid-CONFIRM, then mid-REPORT
        whites4();
        frame(1'b0, C_R, 16'd3000, 1'b0);
        frame(1'b0, C_R, 16'd3000, 1'b0);
        check("pre_rst_confirm", {29'd0, fsm_state}, {29'd0, S_C});
        #3 reset = 1'b0;
        #1;
        check("rst_confirm_all", {dice_valid, dice_value, dice_steps, timeout_pulse, fsm_state}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_release_idle", {29'd0, fsm_state}, {29'd0, S_I});
        tick();
        check("rst_then_wait", {29'd0, fsm_state}, {29'd0, S_W});
        whites4();
        for (int k = 0; k < 4; k++) frame(1'b0, C_B, 16'd3000, 1'b0);
        check("pre_rst_report", {31'd0, dice_valid}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("rst_report_all", {dice_valid, dice_value, dice_steps, timeout_pulse, fsm_state}, 32'd0);
        #2 reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dice_roll_qualifier.md
DICE_ROLL_QUALIFIER -- requirements
Module: dice_roll_qualifier

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 4, meaning consecutive agreeing frames needed to qualify a state (range 1..15).
REQ-002 SHALL have parameter CONF_MIN, default 16'd2000, meaning the minimum stable_confidence for a colour frame to count.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 25_000_000, meaning the maximum clk cycles between frames while confirming.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, high while the game controller awaits a roll.
REQ-007 SHALL have port result_ready, input, 1, one-cycle pulse per analysed frame from the colour detector.
REQ-008 SHALL have port stable_color, input, 2, frame colour code: 0 red, 1 green, 2 blue, 3 none.
REQ-009 SHALL have port white_stable, input, 1, frame shows empty (white) tray; sampled with result_ready.
REQ-010 SHALL have port stable_confidence, input, 16, frame colour pixel count; sampled with result_ready.
REQ-011 SHALL have port dice_ack, input, 1, consumer accepts the reported roll.
REQ-012 SHALL have port dice_valid, output, 1, a qualified roll is held.
REQ-013 SHALL have port dice_value, output, 2, qualified colour code.
REQ-014 SHALL have port dice_steps, output, 3, steps: red 1, green 2, blue 3.
REQ-015 SHALL have port timeout_pulse, output, 1, one-cycle pulse on a confirmation timeout.
REQ-016 SHALL have port fsm_state, output, 3, debug encoding of the current state.

Function
REQ-017 A frame SHALL be "white" when result_ready=1 and white_stable=1, and "colour c" when result_ready=1, white_stable=0, stable_color=c≠3 and stable_confidence>=CONF_MIN; all other frames SHALL be "neutral".
REQ-018 The FSM SHALL have states IDLE, WAIT_WHITE, ARMED, CONFIRM and REPORT.
REQ-019 IDLE SHALL go to WAIT_WHITE when enable=1.
REQ-020 WAIT_WHITE SHALL count consecutive white frames, and a non-white frame SHALL clear the count; at count=STABLE_FRAMES it SHALL go to ARMED.
REQ-021 ARMED SHALL latch c and go to CONFIRM with frame count 1 on the first colour c frame.
REQ-022 In CONFIRM, a colour frame equal to the latched colour SHALL increment the count.
REQ-023 In CONFIRM, a different colour SHALL relatch and set the count to 1.
REQ-024 In CONFIRM, a white frame SHALL return to ARMED.
REQ-025 In CONFIRM, a neutral frame SHALL leave the count unchanged.
REQ-026 When the count reaches STABLE_FRAMES, the FSM SHALL go to REPORT, and dice_valid SHALL assert the cycle after the completing result_ready pulse (1-cycle latency).
REQ-027 In REPORT, dice_valid, dice_value and dice_steps SHALL be held stable until dice_ack=1, then the FSM SHALL go to WAIT_WHITE with dice_valid low the next cycle.
REQ-028 dice_ack outside REPORT SHALL be ignored.
REQ-029 In REPORT, result_ready SHALL be ignored; if it coincides with dice_ack, the ack SHALL win and the frame SHALL be discarded.
REQ-030 In CONFIRM, a cycle counter SHALL reset on every result_ready.
REQ-031 When the CONFIRM cycle counter reaches TIMEOUT_CYCLES-1, the FSM SHALL pulse timeout_pulse for 1 cycle and return to ARMED.
REQ-032 In states other than CONFIRM, the cycle counter SHALL be held at 0.
REQ-033 enable=0 in any state, including REPORT, SHALL go to IDLE next cycle, clear the counters and deassert dice_valid without waiting for an ack.
REQ-034 Frame counters SHALL saturate at STABLE_FRAMES.
REQ-035 The cycle counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide.
REQ-036 dice_steps SHALL be 0 whenever dice_valid=0.

Reset
REQ-037 While reset=0: state IDLE, all counters 0, dice_valid 0, dice_value 0, dice_steps 0, timeout_pulse 0, fsm_state 0.
REQ-038 Reset asserted mid-REPORT SHALL drop dice_valid immediately (asynchronously).
REQ-039 The first state after reset release SHALL be IDLE regardless of enable.

Structure
REQ-040 The colour code enum (RED, GREEN, BLUE, NONE) and the state enum SHALL live in shared package dice_race_pkg, along with the colour-to-steps function.
REQ-041 A single sub-module, frame_streak_counter (a saturating consecutive-match counter with clear/load), SHALL be used for both the white and colour streaks.

Verification
REQ-042 enable=1, 4 white frames, then 4 green frames (conf 3000) -> dice_valid=1, dice_value=1, dice_steps=2 one cycle after the 4th green pulse.
REQ-043 Armed, then red, red, blue, blue, blue, blue -> report blue/3 after the 6th frame; no earlier dice_valid.
REQ-044 Armed, green frames with conf 1999 -> never reports; with conf 2000 -> reports.
REQ-045 In REPORT, hold dice_ack low for 100 frames -> outputs stable. Then pulse dice_ack coinciding with result_ready -> dice_valid=0 next cycle, state WAIT_WHITE, and a second roll requires 4 new white frames.
REQ-046 In CONFIRM (TIMEOUT_CYCLES=50), give no frames for 50 cycles -> one timeout_pulse and state ARMED.
REQ-047 Drop enable in REPORT -> IDLE next cycle. Assert reset mid-CONFIRM -> all outputs 0 immediately.
